// File: rtl/score_hud_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hud_pkg : glyph codes, conversion FSM states and BCD digit type            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package hud_pkg;

  localparam logic [3:0] GLYPH_HEART_FULL  = 4'd10;
  localparam logic [3:0] GLYPH_HEART_EMPTY = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_CONV   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_COMMIT = 3'd4
  } hud_state_t;

  typedef logic [3:0] bcd_t;

endpackage
`default_nettype wire

// File: rtl/score_hud_bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bin2bcd_seq : sequential double-dabble, one shift per clock, done pulse    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bin2bcd_seq
  import hud_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [SCORE_W-1:0]        i_bin,
  output logic                      o_done,
  output logic [NUM_DIGITS*4-1:0]   o_bcd
);

  localparam int CNT_W = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0]      r_sh;
  logic [NUM_DIGITS*4-1:0] r_bcd;
  logic [NUM_DIGITS*4-1:0] w_adj;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_done;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_t'(r_bcd[d*4 +: 4]) >= 4'd5)
        w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_sh  <= i_bin;
        r_bcd <= '0;
        r_cnt <= CNT_W'(SCORE_W);
      end else if (r_cnt != '0) begin
        r_bcd  <= {w_adj[NUM_DIGITS*4-2:0], r_sh[SCORE_W-1]};
        r_sh   <= r_sh << 1;
        r_cnt  <= r_cnt - 1'b1;
        r_done <= (r_cnt == CNT_W'(1));
      end
    end
  end

  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/score_hud.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | score_hud : per-player BCD score and heart bar overlay, 1-cycle pixel path |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module score_hud
  import hud_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_DIGITS   = 4,
  parameter int SCORE_W      = 14,
  parameter int MAX_HP       = 4,
  parameter int CHAR_W       = 30,
  parameter int CHAR_H       = 45,
  parameter int ORIGIN_X     = 510,
  parameter int ROW0_Y       = 90,
  parameter int ROW_PITCH    = 240,
  parameter int HEART_DY     = 60,
  parameter int BLINK_FRAMES = 48,
  parameter int LZ_SUPPRESS  = 1,
  localparam int HP_W        = $clog2(MAX_HP + 1)
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_start,
  input  logic [NUM_PLAYERS*SCORE_W-1:0] score_bin,
  input  logic [NUM_PLAYERS*HP_W-1:0]    hp,
  input  logic [9:0]                     DrawX,
  input  logic [9:0]                     DrawY,
  output logic                           is_char,
  output logic [3:0]                     char_idx,
  output logic [18:0]                    char_read_address,
  output logic                           busy
);

  localparam int PW      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int BLINK_W = ($clog2(BLINK_FRAMES + 1) < 4) ? 4 : $clog2(BLINK_FRAMES + 1);
  localparam int BW      = NUM_DIGITS * 4;
  localparam logic [63:0]   c_SAT_LIMIT = 64'(10 ** NUM_DIGITS);
  localparam logic [BW-1:0] c_ALL_NINES = {NUM_DIGITS{4'h9}};

  hud_state_t r_state, w_next;
  logic [NUM_PLAYERS*SCORE_W-1:0] r_snap;
  logic [NUM_PLAYERS-1:0]         r_sat;
  logic [PW-1:0]                  r_p;
  logic                           r_fin;
  logic [BW-1:0]                  r_shadow [NUM_PLAYERS];
  logic [BW-1:0]                  r_disp   [NUM_PLAYERS];
  logic                           w_start, w_conv_done, w_accept;
  logic [BW-1:0]                  w_bcd;

  logic [HP_W-1:0]    r_prev_hp   [NUM_PLAYERS];
  logic [HP_W-1:0]    r_blink_hi  [NUM_PLAYERS];
  logic [BLINK_W-1:0] r_blink_cnt [NUM_PLAYERS];
  logic [HP_W-1:0]    w_hpc       [NUM_PLAYERS];

  assign w_accept = frame_start && (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);

  bin2bcd_seq #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .i_start (w_start),
    .i_bin   (r_snap[r_p*SCORE_W +: SCORE_W]),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE:   if (frame_start) w_next = ST_LATCH;
      ST_LATCH:  begin w_start = 1'b1; w_next = ST_CONV; end
      ST_CONV:   if (w_conv_done) w_next = ST_NEXT;
      ST_NEXT:   if (r_fin) w_next = ST_COMMIT;
                 else begin w_start = 1'b1; w_next = ST_CONV; end
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Display regs only change in COMMIT so a frame never shows a half-updated score.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_snap  <= '0;
      r_sat   <= '0;
      r_p     <= '0;
      r_fin   <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        r_shadow[p] <= '0;
        r_disp[p]   <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_snap <= score_bin;
        r_p    <= '0;
        r_fin  <= 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++)
          r_sat[p] <= 64'(score_bin[p*SCORE_W +: SCORE_W]) >= c_SAT_LIMIT;
      end
      if ((r_state == ST_CONV) && w_conv_done) begin
        r_shadow[r_p] <= r_sat[r_p] ? c_ALL_NINES : w_bcd;
        if (r_p == PW'(NUM_PLAYERS - 1)) r_fin <= 1'b1;
        else                             r_p   <= r_p + 1'b1;
      end
      if (r_state == ST_COMMIT) begin
        for (int p = 0; p < NUM_PLAYERS; p++) r_disp[p] <= r_shadow[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++)
      w_hpc[p] = (hp[p*HP_W +: HP_W] > HP_W'(MAX_HP)) ? HP_W'(MAX_HP) : hp[p*HP_W +: HP_W];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        r_prev_hp[p]   <= HP_W'(MAX_HP);
        r_blink_hi[p]  <= '0;
        r_blink_cnt[p] <= '0;
      end
    end else if (w_accept) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (w_hpc[p] < r_prev_hp[p]) begin
          r_blink_hi[p]  <= r_prev_hp[p];
          r_blink_cnt[p] <= BLINK_W'(BLINK_FRAMES);
        end else if (w_hpc[p] > r_prev_hp[p]) begin
          r_blink_cnt[p] <= '0;
        end else if (r_blink_cnt[p] != '0) begin
          r_blink_cnt[p] <= r_blink_cnt[p] - 1'b1;
        end
        r_prev_hp[p] <= w_hpc[p];
      end
    end
  end

  function automatic logic in_cell(input logic [31:0] x, y, cx, cy);
    return (x >= cx) && (x < cx + CHAR_W) && (y >= cy) && (y < cy + CHAR_H);
  endfunction

  function automatic logic [18:0] cell_addr(input logic [31:0] x, y, cx, cy);
    logic [31:0] a;
    a = (x - cx) + (y - cy) * CHAR_W;
    return a[18:0];
  endfunction

  logic [NUM_DIGITS-1:0] w_blank      [NUM_PLAYERS];
  logic [MAX_HP-1:0]     w_heart_full [NUM_PLAYERS];
  logic                  w_run;
  logic [31:0]           w_x, w_y;
  logic                  w_hit;
  logic [3:0]            w_idx;
  logic [18:0]           w_addr;

  assign w_x = 32'(DrawX);
  assign w_y = 32'(DrawY);

  // A digit blanks only if it and every more-significant digit are zero; LSD never blanks.
  always_comb begin
    w_run = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_blank[p] = '0;
      w_run      = (LZ_SUPPRESS != 0);
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        w_run         = w_run && (r_disp[p][k*4 +: 4] == 4'd0);
        w_blank[p][k] = w_run;
      end
      for (int j = 0; j < MAX_HP; j++)
        w_heart_full[p][j] = (32'(j) < 32'(r_prev_hp[p])) ||
                             ((32'(j) < 32'(r_blink_hi[p])) && (r_blink_cnt[p] != '0) &&
                              r_blink_cnt[p][3]);
    end
  end

  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_addr = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (!w_hit && !w_blank[p][k] &&
            in_cell(w_x, w_y, 32'(ORIGIN_X + (NUM_DIGITS - 1 - k) * CHAR_W),
                    32'(ROW0_Y + p * ROW_PITCH))) begin
          w_hit  = 1'b1;
          w_idx  = r_disp[p][k*4 +: 4];
          w_addr = cell_addr(w_x, w_y, 32'(ORIGIN_X + (NUM_DIGITS - 1 - k) * CHAR_W),
                             32'(ROW0_Y + p * ROW_PITCH));
        end
      end
      for (int j = 0; j < MAX_HP; j++) begin
        if (!w_hit && in_cell(w_x, w_y, 32'(ORIGIN_X + j * CHAR_W),
                              32'(ROW0_Y + p * ROW_PITCH + HEART_DY))) begin
          w_hit  = 1'b1;
          w_idx  = w_heart_full[p][j] ? GLYPH_HEART_FULL : GLYPH_HEART_EMPTY;
          w_addr = cell_addr(w_x, w_y, 32'(ORIGIN_X + j * CHAR_W),
                             32'(ROW0_Y + p * ROW_PITCH + HEART_DY));
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_char           <= 1'b0;
      char_idx          <= '0;
      char_read_address <= '0;
    end else begin
      is_char           <= w_hit;
      char_idx          <= w_idx;
      char_read_address <= w_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_hud.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_score_hud : directed self-checking bench for score_hud                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_score_hud;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [27:0] score_bin = '0;
  logic [5:0]  hp = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        is_char;
  logic [3:0]  char_idx;
  logic [18:0] char_read_address;
  logic        busy;

  int errors = 0;
  int checks = 0;

  score_hud dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .frame_start       (frame_start),
    .score_bin         (score_bin),
    .hp                (hp),
    .DrawX             (DrawX),
    .DrawY             (DrawY),
    .is_char           (is_char),
    .char_idx          (char_idx),
    .char_read_address (char_read_address),
    .busy              (busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_score(input int s0, input int s1);
    score_bin = {14'(s1), 14'(s0)};
  endtask

  task automatic set_hp(input int h0, input int h1);
    hp = {3'(h1), 3'(h0)};
  endtask

  task automatic probe(input int x, input int y);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk);
    #1;
  endtask

  task automatic px(input string tag, input int x, input int y, input int e_is, input int e_idx);
    probe(x, y);
    chk({tag, "_is"}, 32'(is_char), 32'(e_is));
    chk({tag, "_idx"}, 32'(char_idx), 32'(e_idx));
  endtask

  task automatic pulse();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic frame();
    pulse();
    wait_idle("frame_done");
  endtask

  initial begin
    int n;
    set_score(1234, 7);
    set_hp(4, 7);
    repeat (3) @(negedge Clk);
    chk("rst_is", 32'(is_char), 0);
    chk("rst_idx", 32'(char_idx), 0);
    chk("rst_addr", 32'(char_read_address), 0);
    chk("rst_busy", 32'(busy), 0);
    Reset_n = 1'b1;

    // Conversion length and basic digit layout
    pulse();
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge Clk);
    end
    chk("busy_cycles", 32'(n), 34);
    px("t1_d3", 510, 90, 1, 1);
    chk("t1_addr", 32'(char_read_address), 0);
    px("t1_d2", 540, 90, 1, 2);
    px("t1_d0", 600, 90, 1, 4);
    px("t1_p1d0", 600, 330, 1, 7);
    px("t1_p1lz", 510, 330, 0, 0);
    chk("t1_lz_addr", 32'(char_read_address), 0);
    px("t1_p1hp_clamp", 600, 390, 1, 10);

    // Saturation and address arithmetic
    set_score(12000, 7);
    frame();
    px("t2_d3", 510, 90, 1, 9);
    px("t2_d2", 540, 90, 1, 9);
    px("t2_d1", 570, 90, 1, 9);
    px("t2_d0", 600, 90, 1, 9);
    px("t2_corner", 539, 134, 1, 9);
    chk("t2_addr", 32'(char_read_address), 1349);
    px("t2_below", 539, 135, 0, 0);
    px("t2_right", 630, 90, 0, 0);

    // Heart loss blink: counter 48 after the drop, then one step per frame
    set_hp(2, 7);
    frame();
    px("t3_h0", 510, 150, 1, 10);
    px("t3_h1", 540, 150, 1, 10);
    px("t3_h2_c48", 570, 150, 1, 11);
    px("t3_h3_c48", 600, 150, 1, 11);
    frame();
    px("t3_h2_c47", 570, 150, 1, 10);
    px("t3_h3_c47", 600, 150, 1, 10);
    repeat (7) frame();
    px("t3_h2_c40", 570, 150, 1, 10);
    frame();
    px("t3_h2_c39", 570, 150, 1, 11);
    repeat (31) frame();
    px("t3_h2_c8", 570, 150, 1, 10);
    frame();
    px("t3_h2_c7", 570, 150, 1, 11);
    repeat (7) frame();
    px("t3_h2_c0", 570, 150, 1, 11);
    frame();
    px("t3_h3_steady", 600, 150, 1, 11);
    px("t3_h1_steady", 540, 150, 1, 10);

    // Heart gain cancels an active blink
    set_hp(4, 7);
    frame();
    set_hp(2, 7);
    frame();
    frame();
    px("t4_h3_blink", 600, 150, 1, 10);
    set_hp(3, 7);
    frame();
    px("t4_h2", 570, 150, 1, 10);
    px("t4_h3", 600, 150, 1, 11);

    // No tearing mid-conversion; second frame_start while busy ignored
    set_score(5678, 7);
    frame();
    px("t5_pre", 510, 90, 1, 5);
    set_score(4321, 7);
    pulse();
    repeat (5) @(negedge Clk);
    set_score(1111, 7);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    px("t5_old", 510, 90, 1, 5);
    chk("t5_busy_mid", 32'(busy), 1);
    wait_idle("t5_done");
    px("t5_d3", 510, 90, 1, 4);
    px("t5_d2", 540, 90, 1, 3);
    repeat (10) @(negedge Clk);
    chk("t5_ignored", 32'(busy), 0);

    // Reset during conversion
    set_score(9876, 7);
    set_hp(4, 4);
    pulse();
    repeat (8) @(negedge Clk);
    px("t6_before", 510, 90, 1, 4);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t6_is", 32'(is_char), 0);
    chk("t6_idx", 32'(char_idx), 0);
    chk("t6_addr", 32'(char_read_address), 0);
    chk("t6_busy", 32'(busy), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    px("t6_zero_lsd", 600, 90, 1, 0);
    px("t6_zero_msd", 510, 90, 0, 0);
    px("t6_heart", 600, 150, 1, 10);
    frame();
    px("t6_d3", 510, 90, 1, 9);
    px("t6_d0", 600, 90, 1, 6);
    px("t6_p1", 600, 330, 1, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
